// File: rtl/wm_pkg.sv
// wm_pkg: shared constants and the state encoding for the watermark responder.
//   LEN_I  - width of an input symbol
//   LEN_O  - width of an output symbol
//   CHUNKS - number of signature chunks emitted per signing run
package wm_pkg;

    localparam int LEN_I  = 3;
    localparam int LEN_O  = 5;
    localparam int CHUNKS = 16;
    localparam int CHUNK_W = $clog2(CHUNKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        SIGN = 2'd2
    } state_t;

endpackage

// File: rtl/wm_responder_if.sv
// wm_responder_if: symbol stream between the host FSM / environment and the
// watermark responder.
//   sym_in     - input symbol, one per cycle
//   host_out   - host FSM output, passed through when not signing
//   sym_out    - muxed output symbol
//   sig_active - high while the responder is in SIGN
//   sig_done   - one-cycle pulse after the last chunk
// Modports: master drives the inputs and observes outputs; slave is the responder.
interface wm_responder_if;
    import wm_pkg::*;

    logic [LEN_I-1:0] sym_in;
    logic [LEN_O-1:0] host_out;
    logic [LEN_O-1:0] sym_out;
    logic             sig_active;
    logic             sig_done;

    modport master (
        output sym_in, host_out,
        input  sym_out, sig_active, sig_done
    );

    modport slave (
        input  sym_in, host_out,
        output sym_out, sig_active, sig_done
    );

endinterface

// File: rtl/wm_key_matcher.sv
// wm_key_matcher: tracks progress through the unlock key.
//   clk, reset - rising-edge clock, synchronous active-high reset
//   en         - match incoming symbols (low while signing)
//   abort      - signing aborted this cycle; restart key tracking from sym
//   sym        - input symbol
//   key_hit    - combinational, high in the cycle the last key symbol arrives
//   key_busy   - next key index is non-zero (partial key in progress)
// Mismatch recovery only checks the first key symbol; no deeper overlap search.
module wm_key_matcher
    import wm_pkg::*;
#(
    parameter int                      INIT_LEN = 4,
    parameter logic [LEN_I*INIT_LEN-1:0] INIT_KEY = 12'b101_010_111_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             abort,
    input  logic [LEN_I-1:0] sym,
    output logic             key_hit,
    output logic             key_busy
);

    localparam int IDX_W = (INIT_LEN > 1) ? $clog2(INIT_LEN) : 1;

    logic [IDX_W-1:0] idx, idx_nxt, restart;

    // Key symbol n; symbol 0 sits in the most significant bits.
    function automatic logic [LEN_I-1:0] key_sym(input logic [IDX_W-1:0] n);
        return INIT_KEY[LEN_I*(INIT_LEN-1-int'(n)) +: LEN_I];
    endfunction

    always_comb begin
        idx_nxt = idx;
        key_hit = 1'b0;
        // A one-symbol key has no index 1, so a mismatch always restarts at 0.
        restart = (INIT_LEN > 1 && sym == key_sym('0)) ? IDX_W'(1) : '0;
        if (abort) begin
            idx_nxt = restart;
        end else if (en) begin
            if (sym == key_sym(idx)) begin
                if (idx == IDX_W'(INIT_LEN-1)) begin
                    key_hit = 1'b1;
                    idx_nxt = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end else begin
                idx_nxt = restart;
            end
        end
        key_busy = (idx_nxt != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) idx <= '0;
        else       idx <= idx_nxt;
    end

endmodule

// File: rtl/wm_responder.sv
// wm_responder: watermark responder. After the unlock key is seen on sym_in,
// it replaces host_out with 16 signature chunks, one per cycle (Mealy output).
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - wm_responder_if.slave (sym_in, host_out, sym_out, sig_active, sig_done)
// Build option: define WM_STRICT_EN to require the expected chunk input on
// sym_in; a mismatch aborts signing back to key tracking. Without it every
// SIGN cycle emits the next chunk regardless of sym_in.
module wm_responder
    import wm_pkg::*;
#(
    parameter int                        INIT_LEN = 4,
    parameter logic [LEN_I*INIT_LEN-1:0] INIT_KEY = 12'b101_010_111_000,
    parameter logic [127:0]              SIG      = 128'h0123456789abcdef_fedcba9876543210
) (
    input  logic           clk,
    input  logic           reset,
    wm_responder_if.slave  bus
);

    state_t             state, state_nxt;
    logic [CHUNK_W-1:0] chunk, chunk_nxt;
    logic               done_nxt;
    logic               key_en, key_abort, key_hit, key_busy;
    logic               advance;
    logic [LEN_O-1:0]   sym_out_c;
    logic               sig_active_q, sig_done_q;

    // Chunk k is SIG[127-8k -: 8]: upper 3 bits expected input, lower 5 response.
    function automatic logic [LEN_O-1:0] chunk_resp(input logic [CHUNK_W-1:0] k);
        return SIG[127-LEN_I-8*int'(k) -: LEN_O];
    endfunction

`ifdef WM_STRICT_EN
    function automatic logic [LEN_I-1:0] chunk_exp(input logic [CHUNK_W-1:0] k);
        return SIG[127-8*int'(k) -: LEN_I];
    endfunction
`endif

    wm_key_matcher #(
        .INIT_LEN (INIT_LEN),
        .INIT_KEY (INIT_KEY)
    ) u_key (
        .clk      (clk),
        .reset    (reset),
        .en       (key_en),
        .abort    (key_abort),
        .sym      (bus.sym_in),
        .key_hit  (key_hit),
        .key_busy (key_busy)
    );

    always_comb begin
`ifdef WM_STRICT_EN
        advance = (bus.sym_in == chunk_exp(chunk));
`else
        advance = 1'b1;
`endif
    end

    always_comb begin
        state_nxt = state;
        chunk_nxt = chunk;
        done_nxt  = 1'b0;
        key_en    = 1'b0;
        key_abort = 1'b0;
        sym_out_c = bus.host_out;
        case (state)
            IDLE, KEY: begin
                key_en = 1'b1;
                if (key_hit) begin
                    state_nxt = SIGN;
                    chunk_nxt = '0;
                end else begin
                    state_nxt = key_busy ? KEY : IDLE;
                end
            end
            SIGN: begin
                if (advance) begin
                    sym_out_c = chunk_resp(chunk);
                    if (chunk == CHUNK_W'(CHUNKS-1)) begin
                        state_nxt = IDLE;
                        chunk_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        chunk_nxt = chunk + 1'b1;
                    end
                end else begin
                    // Aborted: the offending symbol may itself start a new key.
                    key_abort = 1'b1;
                    chunk_nxt = '0;
                    state_nxt = key_busy ? KEY : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                chunk_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            chunk        <= '0;
            sig_active_q <= 1'b0;
            sig_done_q   <= 1'b0;
        end else begin
            state        <= state_nxt;
            chunk        <= chunk_nxt;
            sig_active_q <= (state_nxt == SIGN);
            sig_done_q   <= done_nxt;
        end
    end

    assign bus.sym_out    = sym_out_c;
    assign bus.sig_active = sig_active_q;
    assign bus.sig_done   = sig_done_q;

endmodule

// File: tb/tb_wm_responder.sv
// tb_wm_responder: directed scoreboard bench for wm_responder (default params).
// Stimulus pushes the hand-computed expected {sym_out, sig_active, sig_done}
// for each cycle; a negedge monitor pops and compares.
module tb_wm_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wm_responder_if bus();

    wm_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [4:0] out;
        logic       act;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Chunk inputs / responses of SIG 0123456789abcdef_fedcba9876543210.
    logic [2:0] ch_in  [16] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic [4:0] ch_out [16] = '{5'h01, 5'h03, 5'h05, 5'h07, 5'h09, 5'h0b, 5'h0d, 5'h0f,
                                5'h1e, 5'h1c, 5'h1a, 5'h18, 5'h16, 5'h14, 5'h12, 5'h10};

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_total++;
            if (bus.sym_out === e.out && bus.sig_active === e.act && bus.sig_done === e.done)
                n_pass++;
            else
                $display("FAIL %s: got out=%h act=%b done=%b, want out=%h act=%b done=%b",
                         e.name, bus.sym_out, bus.sig_active, bus.sig_done, e.out, e.act, e.done);
        end
    end

    task automatic step(input logic rst, input logic [2:0] s, input logic [4:0] h,
                        input logic [4:0] eo, input logic ea, input logic ed, input string nm);
        reset       = rst;
        bus.sym_in  = s;
        bus.host_out = h;
        if (!rst) sb.push_back('{nm, eo, ea, ed});
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [4:0] h, input string nm);
        step(0, 3'd5, h, h, 0, 0, nm);
        step(0, 3'd2, h, h, 0, 0, nm);
        step(0, 3'd7, h, h, 0, 0, nm);
        step(0, 3'd0, h, h, 0, 0, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bus.sym_in = '0;
        bus.host_out = '0;
        step(1, 3'd0, 5'h00, 5'h00, 0, 0, "rst");
        step(1, 3'd0, 5'h00, 5'h00, 0, 0, "rst");

        // Unlock, then sign all 16 chunks.
        key(5'h0a, "unlock_key");
        for (int k = 0; k < 16; k++)
            step(0, ch_in[k], 5'h0a, ch_out[k], 1, 0, $sformatf("chunk%0d", k));
        step(0, 3'd3, 5'h04, 5'h04, 0, 1, "done_pulse");
        step(0, 3'd3, 5'h04, 5'h04, 0, 0, "done_clear");

        // False key: no unlock.
        step(0, 3'd5, 5'h06, 5'h06, 0, 0, "false_key");
        step(0, 3'd2, 5'h06, 5'h06, 0, 0, "false_key");
        step(0, 3'd7, 5'h06, 5'h06, 0, 0, "false_key");
        step(0, 3'd1, 5'h06, 5'h06, 0, 0, "false_key");
        step(0, 3'd3, 5'h06, 5'h06, 0, 0, "false_key_idle");

        // Key restart: 5,2,5,2,7,0 unlocks after the last 0.
        step(0, 3'd5, 5'h1f, 5'h1f, 0, 0, "restart_key");
        step(0, 3'd2, 5'h1f, 5'h1f, 0, 0, "restart_key");
        step(0, 3'd5, 5'h1f, 5'h1f, 0, 0, "restart_key");
        step(0, 3'd2, 5'h1f, 5'h1f, 0, 0, "restart_key");
        step(0, 3'd7, 5'h1f, 5'h1f, 0, 0, "restart_key");
        step(0, 3'd0, 5'h1f, 5'h1f, 0, 0, "restart_key");
        for (int k = 0; k < 7; k++)
            step(0, ch_in[k], 5'h1f, ch_out[k], 1, 0, $sformatf("restart_chunk%0d", k));

        // Reset at chunk 7, then partial key tail must not unlock.
        step(1, 3'd7, 5'h11, 5'h11, 0, 0, "rst_mid");
        step(0, 3'd7, 5'h11, 5'h11, 0, 0, "after_rst");
        step(0, 3'd0, 5'h11, 5'h11, 0, 0, "tail_only");
        step(0, 3'd0, 5'h11, 5'h11, 0, 0, "no_unlock");
        key(5'h11, "rekey");
        step(0, 3'd0, 5'h11, 5'h01, 1, 0, "rekey_chunk0");

        // Wrong chunk0 input right after a fresh unlock.
        step(1, 3'd0, 5'h08, 5'h08, 0, 0, "rst");
        key(5'h08, "abort_key");
`ifdef WM_STRICT_EN
        step(0, 3'd3, 5'h08, 5'h08, 1, 0, "strict_abort");
        step(0, 3'd5, 5'h08, 5'h08, 0, 0, "strict_idle");
`else
        step(0, 3'd3, 5'h08, 5'h01, 1, 0, "lenient_chunk0");
        step(0, 3'd5, 5'h08, 5'h03, 1, 0, "lenient_chunk1");
`endif

        @(negedge clk);
        #1;
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
